// File: rtl/cd_tick_gen.sv
// cd_tick_gen: clock-enable tick generator for the UART (sample/bit) and the VGA (pixel).
// Latency: every output is registered. A tick appears in the cycle after the edge where
//          the divide counter reaches its limit. A restart appears in the cycle after the
//          edge where the restart condition is seen.
// Backpressure: none; the block is free-running. A reconfiguration strobe (ready low) or a
//               limit change clears the dividers and issues a restart pulse instead.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   baudrate      UART divide limit L_U (sample period = L_U+1 cycles)
//   resolution    VGA divide limit L_V (pixel period = L_V+1 cycles)
//   c_UART_ready  low while the UART limit is being rewritten
//   c_VGA_ready   low while the VGA limit is being rewritten
//   uart_sample_tick / uart_bit_tick / vga_pixel_tick  one-cycle enables
//   uart_restart / vga_restart                         one-cycle "dividers cleared" pulses
module cd_tick_gen #(
   parameter int WIDTH_UART_CLK_LIMIT = 16,
   parameter int WIDTH_VGA_CLK_LIMIT  = 4,
   // Sample ticks per bit tick. Must be a power of two and at least 2.
   parameter int OVERSAMPLE           = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WIDTH_UART_CLK_LIMIT-1:0] baudrate,
   input  logic [WIDTH_VGA_CLK_LIMIT-1:0]  resolution,
   input  logic                            c_UART_ready,
   input  logic                            c_VGA_ready,
   output logic                            uart_sample_tick,
   output logic                            uart_bit_tick,
   output logic                            vga_pixel_tick,
   output logic                            uart_restart,
   output logic                            vga_restart
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   // ------------------------------------------------------------------
   // UART channel state
   // ------------------------------------------------------------------
   logic [WIDTH_UART_CLK_LIMIT-1:0] r_u_cnt;
   logic [OS_W-1:0]                 r_os_cnt;
   logic [WIDTH_UART_CLK_LIMIT-1:0] r_baud_shadow;
   logic                            r_uart_sample_tick;
   logic                            r_uart_bit_tick;
   logic                            r_uart_restart;

   // ------------------------------------------------------------------
   // VGA channel state
   // ------------------------------------------------------------------
   logic [WIDTH_VGA_CLK_LIMIT-1:0]  r_v_cnt;
   logic [WIDTH_VGA_CLK_LIMIT-1:0]  r_res_shadow;
   logic                            r_vga_pixel_tick;
   logic                            r_vga_restart;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic w_uart_restart;
   logic w_uart_term;
   logic w_os_last;
   logic w_vga_restart;
   logic w_vga_term;

   // A limit that differs from the value seen last cycle is treated exactly like a
   // ready-low strobe, so the divide counter can never be left above a lowered limit.
   always_comb begin
      w_uart_restart = !c_UART_ready || (baudrate != r_baud_shadow);
      w_vga_restart  = !c_VGA_ready  || (resolution != r_res_shadow);
   end

   // '>=' rather than '==' keeps the divider from running the full counter range
   // should the count ever exceed the limit.
   always_comb begin
      w_uart_term = (r_u_cnt >= baudrate);
      w_vga_term  = (r_v_cnt >= resolution);
      w_os_last   = (r_os_cnt == OS_LAST);
   end

   // ------------------------------------------------------------------
   // UART divider + oversample stage
   // ------------------------------------------------------------------
   // The shadow follows the live limit while reset is held, so releasing reset
   // does not by itself look like a reconfiguration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_u_cnt            <= '0;
         r_os_cnt           <= '0;
         r_baud_shadow      <= baudrate;
         r_uart_sample_tick <= 1'b0;
         r_uart_bit_tick    <= 1'b0;
         r_uart_restart     <= 1'b0;
      end else if (w_uart_restart) begin
         // Restart has priority over a coincident terminal count: no tick is issued.
         r_u_cnt            <= '0;
         r_os_cnt           <= '0;
         r_baud_shadow      <= baudrate;
         r_uart_sample_tick <= 1'b0;
         r_uart_bit_tick    <= 1'b0;
         r_uart_restart     <= 1'b1;
      end else if (w_uart_term) begin
         r_u_cnt            <= '0;
         r_os_cnt           <= w_os_last ? '0 : r_os_cnt + OS_W'(1);
         r_uart_sample_tick <= 1'b1;
         r_uart_bit_tick    <= w_os_last;
         r_uart_restart     <= 1'b0;
      end else begin
         r_u_cnt            <= r_u_cnt + WIDTH_UART_CLK_LIMIT'(1);
         r_uart_sample_tick <= 1'b0;
         r_uart_bit_tick    <= 1'b0;
         r_uart_restart     <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // VGA divider
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v_cnt          <= '0;
         r_res_shadow     <= resolution;
         r_vga_pixel_tick <= 1'b0;
         r_vga_restart    <= 1'b0;
      end else if (w_vga_restart) begin
         r_v_cnt          <= '0;
         r_res_shadow     <= resolution;
         r_vga_pixel_tick <= 1'b0;
         r_vga_restart    <= 1'b1;
      end else if (w_vga_term) begin
         r_v_cnt          <= '0;
         r_vga_pixel_tick <= 1'b1;
         r_vga_restart    <= 1'b0;
      end else begin
         r_v_cnt          <= r_v_cnt + WIDTH_VGA_CLK_LIMIT'(1);
         r_vga_pixel_tick <= 1'b0;
         r_vga_restart    <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign uart_sample_tick = r_uart_sample_tick;
   assign uart_bit_tick    = r_uart_bit_tick;
   assign uart_restart     = r_uart_restart;
   assign vga_pixel_tick   = r_vga_pixel_tick;
   assign vga_restart      = r_vga_restart;

endmodule

// File: tb/tb_cd_tick_gen.sv
module tb_cd_tick_gen;

   localparam int WU = 16;
   localparam int WV = 4;
   localparam int OS = 16;

   logic          clk;
   logic          rst;
   logic [WU-1:0] baudrate;
   logic [WV-1:0] resolution;
   logic          c_UART_ready;
   logic          c_VGA_ready;
   logic          uart_sample_tick;
   logic          uart_bit_tick;
   logic          vga_pixel_tick;
   logic          uart_restart;
   logic          vga_restart;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 0;

   cd_tick_gen #(
      .WIDTH_UART_CLK_LIMIT(WU),
      .WIDTH_VGA_CLK_LIMIT (WV),
      .OVERSAMPLE          (OS)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .baudrate        (baudrate),
      .resolution      (resolution),
      .c_UART_ready    (c_UART_ready),
      .c_VGA_ready     (c_VGA_ready),
      .uart_sample_tick(uart_sample_tick),
      .uart_bit_tick   (uart_bit_tick),
      .vga_pixel_tick  (vga_pixel_tick),
      .uart_restart    (uart_restart),
      .vga_restart     (vga_restart)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: each channel tracks how many clean edges have passed
   // since its last clear. A tick is due whenever that count is a multiple of
   // the period (L+1); a bit tick whenever it is a multiple of OS*(L+1).
   // ------------------------------------------------------------------
   int            pu, pv;
   logic [WU-1:0] m_baud;
   logic [WV-1:0] m_res;
   logic          e_st, e_bt, e_ur, e_pt, e_vr;

   initial begin
      pu = 0; pv = 0; e_st = 0; e_bt = 0; e_ur = 0; e_pt = 0; e_vr = 0;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pu = 0; pv = 0;
         m_baud = baudrate; m_res = resolution;
         e_st = 0; e_bt = 0; e_ur = 0; e_pt = 0; e_vr = 0;
      end else begin
         if (!c_UART_ready || baudrate != m_baud) begin
            pu = 0; m_baud = baudrate;
            e_st = 0; e_bt = 0; e_ur = 1;
         end else begin
            pu++;
            e_st = (pu % (int'(m_baud) + 1)) == 0;
            e_bt = (pu % (OS * (int'(m_baud) + 1))) == 0;
            e_ur = 0;
         end
         if (!c_VGA_ready || resolution != m_res) begin
            pv = 0; m_res = resolution;
            e_pt = 0; e_vr = 1;
         end else begin
            pv++;
            e_pt = (pv % (int'(m_res) + 1)) == 0;
            e_vr = 0;
         end
      end
   end

   // Per-cycle comparison on the falling edge, away from the update edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_uart_sample_tick", uart_sample_tick, e_st);
         chk("model_uart_bit_tick",    uart_bit_tick,    e_bt);
         chk("model_uart_restart",     uart_restart,     e_ur);
         chk("model_vga_pixel_tick",   vga_pixel_tick,   e_pt);
         chk("model_vga_restart",      vga_restart,      e_vr);
      end
   end

   // Advance one clock; inputs are driven and literals sampled 2 time units after the edge.
   task automatic step();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic reset_release();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      cyc = 0;
   endtask

   task automatic reset_seq();
      @(posedge clk);
      #1 rst = 1'b0;
      reset_release();
   endtask

   initial begin
      rst          = 1'b0;
      baudrate     = 16'd3;
      resolution   = 4'd1;
      c_UART_ready = 1'b1;
      c_VGA_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("reset_sample_tick", uart_sample_tick, 1'b0);
      chk("reset_bit_tick",    uart_bit_tick,    1'b0);
      chk("reset_pixel_tick",  vga_pixel_tick,   1'b0);
      chk("reset_uart_restart", uart_restart,    1'b0);
      chk("reset_vga_restart",  vga_restart,     1'b0);
      chk_en = 1;

      // Scenario 1: baudrate=3, resolution=1 from reset release
      reset_release();
      for (int n = 1; n <= 70; n++) begin
         step();
         if (n == 1) chk("s1_pixel_c1", vga_pixel_tick, 1'b0);
         if (n == 2) chk("s1_pixel_c2", vga_pixel_tick, 1'b1);
         if (n == 3) chk("s1_sample_c3", uart_sample_tick, 1'b0);
         if (n == 4) chk("s1_sample_c4", uart_sample_tick, 1'b1);
         if (n == 8) chk("s1_sample_c8", uart_sample_tick, 1'b1);
         if (n == 60) chk("s1_bit_c60", uart_bit_tick, 1'b0);
         if (n == 64) begin
            chk("s1_bit_c64", uart_bit_tick, 1'b1);
            chk("s1_sample_c64", uart_sample_tick, 1'b1);
         end
      end

      // Scenario 2: zero limits -> continuous enables
      baudrate = 16'd0;
      resolution = 4'd0;
      reset_seq();
      for (int n = 1; n <= 33; n++) begin
         step();
         if (n == 1) begin
            chk("s2_sample_c1", uart_sample_tick, 1'b1);
            chk("s2_pixel_c1",  vga_pixel_tick,   1'b1);
         end
         if (n == 15) chk("s2_bit_c15", uart_bit_tick, 1'b0);
         if (n == 16) chk("s2_bit_c16", uart_bit_tick, 1'b1);
         if (n == 32) chk("s2_bit_c32", uart_bit_tick, 1'b1);
      end

      // Scenario 3: baudrate=9, ready strobe at u_cnt=6, os_cnt=5 (56 edges in)
      baudrate = 16'd9;
      resolution = 4'd1;
      reset_seq();
      steps(56);
      c_UART_ready = 1'b0;
      step();   // restart edge: cycle 57
      chk("s3_restart_hi", uart_restart, 1'b1);
      chk("s3_no_tick",    uart_sample_tick, 1'b0);
      c_UART_ready = 1'b1;
      step();
      chk("s3_restart_lo", uart_restart, 1'b0);
      steps(8);  // cycle 66
      chk("s3_sample_c66", uart_sample_tick, 1'b0);
      step();
      chk("s3_sample_c67", uart_sample_tick, 1'b1);
      steps(216 - 67);
      chk("s3_bit_c216", uart_bit_tick, 1'b0);
      step();
      chk("s3_bit_c217", uart_bit_tick, 1'b1);

      // Scenario 4: limit 9 -> 4 with ready held high
      baudrate = 16'd4;
      step();
      chk("s4_restart_hi", uart_restart, 1'b1);
      step();
      chk("s4_restart_lo", uart_restart, 1'b0);
      steps(3);
      chk("s4_sample_p4", uart_sample_tick, 1'b0);
      step();
      chk("s4_sample_p5", uart_sample_tick, 1'b1);
      steps(5);
      chk("s4_sample_p10", uart_sample_tick, 1'b1);

      // Scenario 5: VGA ready low 3 cycles, resolution=2
      resolution = 4'd2;
      steps(6);
      c_VGA_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("s5_vga_restart_hi", vga_restart, 1'b1);
         chk("s5_pixel_suppressed", vga_pixel_tick, 1'b0);
      end
      c_VGA_ready = 1'b1;
      step();
      chk("s5_vga_restart_lo", vga_restart, 1'b0);
      chk("s5_pixel_r1", vga_pixel_tick, 1'b0);
      step();
      chk("s5_pixel_r2", vga_pixel_tick, 1'b0);
      step();
      chk("s5_pixel_r3", vga_pixel_tick, 1'b1);

      // Scenario 6: async reset mid-count (u_cnt=7, os_cnt=11)
      baudrate = 16'd9;
      resolution = 4'd0;
      reset_seq();
      steps(117);
      chk("s6_pixel_before", vga_pixel_tick, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk("s6_async_sample", uart_sample_tick, 1'b0);
      chk("s6_async_bit",    uart_bit_tick,    1'b0);
      chk("s6_async_pixel",  vga_pixel_tick,   1'b0);
      chk("s6_async_urst",   uart_restart,     1'b0);
      chk("s6_async_vrst",   vga_restart,      1'b0);
      baudrate = 16'd3;
      resolution = 4'd1;
      reset_release();
      for (int n = 1; n <= 64; n++) begin
         step();
         if (n == 2)  chk("s6_pixel_c2",  vga_pixel_tick,   1'b1);
         if (n == 3)  chk("s6_sample_c3", uart_sample_tick, 1'b0);
         if (n == 4)  chk("s6_sample_c4", uart_sample_tick, 1'b1);
         if (n == 64) chk("s6_bit_c64",   uart_bit_tick,    1'b1);
      end

      // Random reconfiguration traffic, checked by the model every cycle
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 39) == 0) baudrate = 16'($urandom_range(0, 5));
         if ($urandom_range(0, 39) == 0) resolution = 4'($urandom_range(0, 15));
         c_UART_ready = ($urandom_range(0, 19) != 0);
         c_VGA_ready  = ($urandom_range(0, 19) != 0);
         step();
      end

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cd_tick_gen.md
Name: cd_tick_gen

Overview:
- Clock-divider tick generator; sits directly downstream of the clock-divider configuration block.
- Consumes its `baudrate` / `resolution` counter limits and its `c_UART_ready` / `c_VGA_ready` strobes.
- Produces single-cycle clock-enable ticks for the UART (oversample tick and bit tick) and the VGA (pixel tick).
- Also produces restart pulses so the UART and VGA engines resynchronise after a reconfiguration.

Parameters:
- WIDTH_UART_CLK_LIMIT, 16: width of the `baudrate` limit and the UART divide counter.
- WIDTH_VGA_CLK_LIMIT, 4: width of the `resolution` limit and the VGA divide counter.
- OVERSAMPLE, 16: UART sample ticks per bit tick; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- baudrate  in  WIDTH_UART_CLK_LIMIT  UART divide limit L_U.
- resolution  in  WIDTH_VGA_CLK_LIMIT  VGA divide limit L_V.
- c_UART_ready  in  1  low for one or more cycles when the UART limit has just been rewritten.
- c_VGA_ready  in  1  low for one or more cycles when the VGA limit has just been rewritten.
- uart_sample_tick  out  1  one-cycle enable, period L_U+1 cycles.
- uart_bit_tick  out  1  one-cycle enable, coincident with every OVERSAMPLE-th sample tick.
- vga_pixel_tick  out  1  one-cycle enable, period L_V+1 cycles.
- uart_restart  out  1  one-cycle pulse: UART dividers were cleared.
- vga_restart  out  1  one-cycle pulse: VGA divider was cleared.

Behaviour:
- Reset (rst=0, async):
  - u_cnt=0, os_cnt=0, v_cnt=0.
  - Shadow registers: baud_shadow=baudrate, res_shadow=resolution, sampled while reset is asserted.
  - All five outputs = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- UART restart condition (R_U): c_UART_ready==0, or baudrate != baud_shadow.
- UART channel, on each rising edge:
  - If R_U:
    - u_cnt<=0, os_cnt<=0, baud_shadow<=baudrate.
    - uart_sample_tick<=0, uart_bit_tick<=0, uart_restart<=1.
  - Else if u_cnt>=baudrate:
    - u_cnt<=0, uart_sample_tick<=1, uart_restart<=0.
    - os_cnt<=os_cnt+1, wrapping from OVERSAMPLE-1 to 0.
    - uart_bit_tick<=1 only when os_cnt==OVERSAMPLE-1; else 0.
  - Else: u_cnt<=u_cnt+1; both ticks and uart_restart <=0.
- VGA channel: identical structure.
  - Restart condition R_V: c_VGA_ready==0, or resolution != res_shadow.
  - Uses v_cnt, res_shadow, vga_pixel_tick, vga_restart.
  - Has no oversample stage.
- Timing:
  - After reset release or a restart, the first sample/pixel tick is high in the cycle after edge L+1.
  - Thereafter the tick is high one cycle in every L+1.
  - First uart_bit_tick arrives OVERSAMPLE*(L_U+1) cycles after restart.
- Boundary conditions:
  - L=0: tick is high every cycle after the first edge (continuous enable). Bit tick is high one cycle in OVERSAMPLE.
  - L at maximum (all ones): the counter reaches the limit without overflow; `>=` is used so no wrap occurs.
  - Limit lowered below the current count without a restart condition: impossible by construction, since the change itself triggers a restart. The `>=` compare is the safety net.
  - Ready held low for N cycles: counters held at 0; restart high for N cycles; ticks suppressed.
  - Restart coincident with a terminal count: restart wins, and no tick is issued.
  - UART and VGA channels are fully independent; simultaneous events in both are each handled per their own rules.
  - Reset asserted mid-count: immediate clear of all state and outputs, regardless of clk.
- Counter arithmetic is unsigned, at the stated widths.
- os_cnt width = log2(OVERSAMPLE).

Test Plan:
- Reset release with baudrate=3, resolution=1, ready=1:
  - uart_sample_tick high at cycles 4, 8, 12, …
  - vga_pixel_tick high at cycles 2, 4, 6, …
  - uart_bit_tick first high at cycle 64, together with sample tick 16.
- resolution=0, baudrate=0: vga_pixel_tick and uart_sample_tick high every cycle from cycle 1; uart_bit_tick high every 16th cycle.
- baudrate=9, with c_UART_ready driven low for 1 cycle when u_cnt=6 and os_cnt=5:
  - uart_restart high exactly 1 cycle; no tick that cycle.
  - Next sample tick 10 cycles after the restart edge; bit tick 160 cycles after.
  - VGA ticks unaffected.
- baudrate changed 9→4 with c_UART_ready held high: uart_restart pulses once; sample period becomes 5 cycles immediately afterwards.
- c_VGA_ready low for 3 cycles with resolution=2:
  - vga_restart high 3 cycles; v_cnt stays 0.
  - First pixel tick 3 cycles after ready returns high.
- rst pulsed low mid-count (u_cnt=7, os_cnt=11): all outputs drop to 0 asynchronously; after release, timing restarts exactly as in the first scenario.
